// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
// Each grant pulses send/ack for one cycle, then follows tx_ready low and back high to close the frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int ACCEPT_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    localparam logic [7:0]      TIMEOUT_LAST = 8'(ACCEPT_TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_ID      = ID_W'(NUM_REQ - 1);

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [7:0]         timer;
    logic [7:0]         timer_next;

    logic [NUM_REQ-1:0] req_ack_next;
    logic               tx_send_next;
    logic [7:0]         tx_data_next;
    logic               busy_next;
    logic [ID_W-1:0]    grant_id_next;
    logic               timeout_err_next;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;

    // Pointer increment wraps at NUM_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (v == LAST_ID) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_next       = state;
        rr_ptr_next      = rr_ptr;
        timer_next       = timer;
        req_ack_next     = req_ack;
        tx_send_next     = tx_send;
        tx_data_next     = tx_data;
        busy_next        = busy;
        grant_id_next    = grant_id;
        timeout_err_next = timeout_err;

        case (state)
            IDLE: begin
                if (tx_ready && found) begin
                    tx_data_next         = req_data[{winner, 3'b000} +: 8];
                    grant_id_next        = winner;
                    tx_send_next         = 1'b1;
                    req_ack_next         = '0;
                    req_ack_next[winner] = 1'b1;
                    busy_next            = 1'b1;
                    rr_ptr_next          = wrap_inc(winner);
                    state_next           = SEND;
                end
            end
            SEND: begin
                tx_send_next = 1'b0;
                req_ack_next = '0;
                timer_next   = '0;
                state_next   = WAIT_LOW;
            end
            // A serializer that never drops ready did not take the byte; give up after the timeout.
            WAIT_LOW: begin
                if (!tx_ready) begin
                    state_next = WAIT_HIGH;
                end else if (timer == TIMEOUT_LAST) begin
                    timeout_err_next = 1'b1;
                    busy_next        = 1'b0;
                    state_next       = IDLE;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            timer       <= '0;
            req_ack     <= '0;
            tx_send     <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            timer       <= timer_next;
            req_ack     <= req_ack_next;
            tx_send     <= tx_send_next;
            tx_data     <= tx_data_next;
            busy        <= busy_next;
            grant_id    <= grant_id_next;
            timeout_err <= timeout_err_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames,
// checked against a transaction-level round-robin / frame-timing model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int ID_W           = 2;
    localparam int ACCEPT_TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_send;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_err;

    int checks = 0;
    int errors = 0;

    int         model_rr   = 0;
    int         model_gid  = 0;
    logic       model_err  = 1'b0;
    logic [7:0] model_data = 8'h00;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ack(req_ack),
        .tx_send(tx_send),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First valid requester at or after ptr, modulo NUM_REQ.
    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx = (ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_send"}, tx_send, 1'b0);
        checkOutput({tag, "_ack"}, req_ack, '0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_gid"}, grant_id, model_gid);
        checkOutput({tag, "_data"}, tx_data, model_data);
        checkOutput({tag, "_err"}, timeout_err, model_err);
    endtask

    task automatic checkGrant(input int w, input logic [31:0] data);
        model_data = data[8*w +: 8];
        model_gid  = w;
        model_rr   = (w + 1) % NUM_REQ;
        checkOutput("grant_send", tx_send, 1'b1);
        checkOutput("grant_ack", req_ack, 32'(1) << w);
        checkOutput("grant_data", tx_data, model_data);
        checkOutput("grant_id", grant_id, w);
        checkOutput("grant_busy", busy, 1'b1);
        checkOutput("grant_err", timeout_err, model_err);
    endtask

    // Called in the SEND cycle with tx_ready high; drives the serializer side to the end of the frame.
    task automatic completeFrame(input bit accept, input int drop_delay, input int low_len);
        step();
        checkOutput("post_send", tx_send, 1'b0);
        checkOutput("post_ack", req_ack, '0);
        checkOutput("post_busy", busy, 1'b1);
        checkOutput("post_data", tx_data, model_data);
        if (accept) begin
            for (int i = 0; i < drop_delay; i++) begin
                step();
                checkOutput("wait_low_busy", busy, 1'b1);
            end
            tx_ready = 1'b0;
            for (int i = 0; i < low_len; i++) begin
                step();
                checkOutput("wait_high_busy", busy, 1'b1);
                checkOutput("wait_high_send", tx_send, 1'b0);
            end
            tx_ready = 1'b1;
            step();
            checkOutput("frame_done_busy", busy, 1'b0);
            checkOutput("frame_done_err", timeout_err, model_err);
        end else begin
            for (int i = 0; i < ACCEPT_TIMEOUT - 1; i++) begin
                step();
                checkOutput("timeout_pending_busy", busy, 1'b1);
                checkOutput("timeout_pending_err", timeout_err, model_err);
            end
            step();
            model_err = 1'b1;
            checkOutput("timeout_busy", busy, 1'b0);
            checkOutput("timeout_err", timeout_err, 1'b1);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] pattern, input logic [31:0] data,
                                 input bit accept, input int drop_delay, input int low_len);
        int w;
        w         = rr_pick(model_rr, pattern);
        tx_ready  = 1'b1;
        req_valid = pattern;
        req_data  = data;
        step();
        checkGrant(w, data);
        req_valid = '0;
        req_data  = $urandom;
        completeFrame(accept, drop_delay, low_len);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        step();
        step();
        checkIdle("reset");
        reset = 1'b0;
        step();
        checkIdle("after_reset");

        // Single request on port 2 with byte A5.
        applyStimulus(4'b0100, 32'h00A5_0000, 1'b1, 0, 5);
        checkIdle("single_idle");

        // Everyone valid: strict rotation.
        for (int n = 0; n < 5; n++)
            applyStimulus(4'b1111, $urandom, 1'b1, n % 3, 2 + n);

        // Force pointer to 3, then only 0 and 1 pending.
        applyStimulus(4'b0100, $urandom, 1'b1, 0, 1);
        applyStimulus(4'b0011, $urandom, 1'b1, 0, 3);
        checkOutput("wrap_gid", grant_id, 0);
        applyStimulus(4'b0011, $urandom, 1'b1, 1, 3);
        checkOutput("skip_gid", grant_id, 1);

        // Serializer ignores the send pulse.
        applyStimulus(4'b0010, $urandom, 1'b0, 0, 0);
        applyStimulus(4'b0001, $urandom, 1'b1, ACCEPT_TIMEOUT - 1, 4);
        checkOutput("err_sticky", timeout_err, 1'b1);

        // Blocked start: serializer busy externally.
        begin
            logic [31:0] d;
            int          w;
            d         = $urandom;
            tx_ready  = 1'b0;
            req_valid = 4'b0001;
            req_data  = d;
            for (int i = 0; i < 20; i++) begin
                step();
                checkOutput("blocked_send", tx_send, 1'b0);
                checkOutput("blocked_ack", req_ack, '0);
            end
            w        = rr_pick(model_rr, 4'b0001);
            tx_ready = 1'b1;
            step();
            checkGrant(w, d);
            req_valid = '0;
            completeFrame(1'b1, 2, 6);
        end

        // Reset while waiting for the frame to finish.
        begin
            logic [31:0] d;
            d         = $urandom;
            tx_ready  = 1'b1;
            req_valid = 4'b0100;
            req_data  = d;
            step();
            checkGrant(rr_pick(model_rr, 4'b0100), d);
            req_valid = '0;
            step();
            tx_ready = 1'b0;
            step();
            step();
            checkOutput("mid_frame_busy", busy, 1'b1);
            reset = 1'b1;
            step();
            reset      = 1'b0;
            model_rr   = 0;
            model_gid  = 0;
            model_err  = 1'b0;
            model_data = 8'h00;
            checkIdle("mid_reset");
            d         = $urandom;
            req_valid = 4'b1000;
            req_data  = d;
            for (int i = 0; i < 3; i++) begin
                step();
                checkOutput("post_reset_blocked", tx_send, 1'b0);
            end
            tx_ready = 1'b1;
            step();
            checkGrant(3, d);
            req_valid = '0;
            completeFrame(1'b1, 0, 3);
        end

        // Randomized frames with idle gaps.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), $urandom,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, ACCEPT_TIMEOUT - 1), $urandom_range(1, 12));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                step();
                checkIdle("rand_gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers (e.g. debug console, result dumper, status reporter) using round-robin arbitration.
- Drives the serializer's send/data_in pair, tracks its ready handshake through one full frame, and acknowledges each requester when its byte is committed.
- Sits between the producers and uart_tx; all signals are on the 50 MHz system clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- ACCEPT_TIMEOUT, 15, cycles to wait for tx_ready to fall after a send pulse before flagging an error (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte pending.
- req_data  input  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i captured.
- tx_send  output  1  to uart_tx send; one-cycle pulse.
- tx_data  output  8  to uart_tx data_in; registered.
- tx_ready  input  1  from uart_tx ready.
- busy  output  1  high from grant until frame complete or timeout.
- grant_id  output  ID_W  index of the last granted requester.
- timeout_err  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, clk edge with reset=1) sets:
  - req_ack=0, tx_send=0, tx_data=0, busy=0, grant_id=0, timeout_err=0.
  - rr_ptr=0, timer=0, state=IDLE.
  - Reset overrides every state, including mid-frame. uart_tx shares the same reset.
- All outputs are registered. The FSM has four states: IDLE, SEND, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - Grants only when tx_ready=1 and |req_valid.
  - Winner: first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On the grant edge: tx_data<=req_data[winner], grant_id<=winner, tx_send<=1, req_ack[winner]<=1, busy<=1, rr_ptr<=(winner+1) mod NUM_REQ, state<=SEND.
  - Otherwise hold all outputs and stay in IDLE. A requester may drop req_valid in IDLE without penalty.
- SEND (exactly 1 cycle):
  - tx_send and req_ack are high during this cycle; uart_tx samples send&&ready at its end.
  - Next edge: tx_send<=0, req_ack<=0, timer<=0, state<=WAIT_LOW.
- WAIT_LOW:
  - tx_ready=0: state<=WAIT_HIGH.
  - Else if timer==ACCEPT_TIMEOUT-1: timeout_err<=1, busy<=0, state<=IDLE.
  - Else timer<=timer+1.
- WAIT_HIGH:
  - Waits indefinitely for tx_ready=1, then busy<=0, state<=IDLE. There is no timeout in this state.
- Latency:
  - Request seen in IDLE at edge k: tx_send and req_ack high in cycle k+1.
  - Earliest next grant is the edge after tx_ready returns high. At least 4 cycles separate consecutive tx_send pulses.
- Requester contract:
  - Hold req_valid and req_data stable until req_ack.
  - After req_ack, data is already in tx_data, so the requester may change it immediately.
  - req_valid still high in the cycle after ack is treated as a new byte.
- Fairness:
  - rr_ptr always advances past the winner, so with all requesters valid the grant order is 0,1,2,3,0,...
  - Wrap-around: a winner of NUM_REQ-1 sets rr_ptr=0.
- tx_ready=0 while in IDLE (serializer externally busy): no grant, no ack.
- timeout_err clears only on reset. The arbiter continues operating after a timeout.
- Arithmetic:
  - rr_ptr is ID_W bits and wraps modulo NUM_REQ, not modulo 2^ID_W.
  - timer is 8 bits.

Test Plan:
- Single request: req_valid=4'b0100, req_data[23:16]=8'hA5, tx_ready=1 → next cycle tx_send=1, tx_data=8'hA5, req_ack=4'b0100, grant_id=2. Both pulses last 1 cycle. busy stays high until the real uart_tx (BAUD_RATE shrunk for sim) re-asserts ready; serial line shows 0xA5.
- Round-robin: req_valid=4'b1111 held, each byte distinct → grant_id sequence 0,1,2,3,0 with one ack per frame. No requester is granted twice before all others are served.
- Wrap/skip: rr_ptr=3, req_valid=4'b0011 → requester 0 granted, then 1; requesters 2 and 3 never acked.
- Timeout: tx_ready stub held at 1, request on port 1 → exactly ACCEPT_TIMEOUT cycles after SEND, timeout_err=1 and busy=0. A new request is then granted normally with timeout_err still 1.
- Reset mid-frame: reset=1 for 1 cycle while in WAIT_HIGH → next cycle all outputs 0 and rr_ptr=0. With req_valid=4'b1000 pending after reset, grant_id=3 once tx_ready=1.
- Blocked start: tx_ready=0, req_valid=4'b0001 for 20 cycles → no tx_send or req_ack. Raise tx_ready → ack exactly one cycle later.
